propose_sequencer: RTL

Sequences the integer/continuous proposal datapath (two clause reducers, two max-C comparators, segment selector) over every integer variable in turn. For each variable the block does the following:
- pulses the datapath resets;
- enables the reducers, then the segment selector, for programmable settling/latency windows;
- supplies a per-iteration seed from an internal LFSR;
- captures the chosen segment's type and weight.

It sits between the top-level sampler FSM (start/abort/done) and the propose datapath's enable/reset/seed/index inputs.

---
 rtl/propose_sequencer.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/propose_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : propose_sequencer
// Purpose  : Walks the integer/continuous proposal datapath over every integer
//            variable in turn. Per variable: pulse datapath resets, enable the
//            reducers, then the segment selector, for fixed dwell windows, and
//            capture the chosen segment type/weight. A maximal-length 8-bit
//            LFSR supplies the per-iteration selector seed.
// Ports    : in_clock/in_reset      clock, async active-low reset
//            in_start/in_abort      run control from sampler FSM
//            in_seed                initial LFSR seed (latched on start)
//            in_segment_type/weight selector result
//            out_reset_*/out_enable_* datapath controls
//            out_seed_select, out_variable_index per-iteration datapath inputs
//            out_sample_*           captured result (valid pulse + data)
//            out_weight_sum         saturating per-run weight sum
//            out_busy/out_done      run status
// Revision : 1.0  initial release
// ============================================================================
module propose_sequencer #(
  parameter int NUM_VARIABLES = 4,
  parameter int INDEX_WIDTH   = 2,
  parameter int REDUCE_CYCLES = 2,
  parameter int SELECT_CYCLES = 3
) (
  input  logic                   in_clock,
  input  logic                   in_reset,
  input  logic                   in_start,
  input  logic                   in_abort,
  input  logic [7:0]             in_seed,
  input  logic [1:0]             in_segment_type,
  input  logic [7:0]             in_segment_weight,
  output logic                   out_reset_reduce,
  output logic                   out_enable_reduce,
  output logic                   out_reset_select,
  output logic                   out_enable_select,
  output logic [7:0]             out_seed_select,
  output logic [INDEX_WIDTH-1:0] out_variable_index,
  output logic                   out_sample_valid,
  output logic [1:0]             out_sample_type,
  output logic [7:0]             out_sample_weight,
  output logic [15:0]            out_weight_sum,
  output logic                   out_busy,
  output logic                   out_done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_REDUCE  = 3'd2;
  localparam logic [2:0] S_SELECT  = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  // Dwell counter only ever holds (cycles-1), so clog2(max cycles) bits suffice.
  localparam int CNT_MAX = (REDUCE_CYCLES > SELECT_CYCLES) ? REDUCE_CYCLES : SELECT_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]       C_RED_LOAD = CNT_W'(REDUCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]       C_SEL_LOAD = CNT_W'(SELECT_CYCLES - 1);
  localparam logic [CNT_W-1:0]       C_CNT_ONE  = CNT_W'(1);
  localparam logic [INDEX_WIDTH-1:0] C_LAST_IDX = INDEX_WIDTH'(NUM_VARIABLES - 1);
  localparam logic [INDEX_WIDTH-1:0] C_IDX_ONE  = INDEX_WIDTH'(1);

  // Core state
  logic [2:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [7:0]             lfsr_q, lfsr_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  logic [15:0]            sum_q, sum_d;
  logic [1:0]             type_q, type_d;
  logic [7:0]             weight_q, weight_d;

  // Registered Moore outputs (decoded from next state so they line up with it)
  logic                   rst_red_q, en_red_q, rst_sel_q, en_sel_q;
  logic                   valid_q, done_q, busy_q;
  logic [7:0]             seed_q;

  logic [16:0]            w_sum_ext;
  logic                   w_in_iter;

  assign w_sum_ext = {1'b0, sum_q} + {9'd0, in_segment_weight};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lfsr_d   = lfsr_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    type_d   = type_q;
    weight_d = weight_q;

    case (state_q)
      S_IDLE: begin
        // Simultaneous start and abort in IDLE is treated as no start.
        if (in_start && !in_abort) begin
          lfsr_d  = (in_seed == 8'h00) ? 8'h01 : in_seed;
          idx_d   = '0;
          sum_d   = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        cnt_d   = C_RED_LOAD;
        state_d = S_REDUCE;
      end
      S_REDUCE: begin
        if (cnt_q == '0) begin
          cnt_d   = C_SEL_LOAD;
          state_d = S_SELECT;
        end else begin
          cnt_d = cnt_q - C_CNT_ONE;
        end
      end
      S_SELECT: begin
        if (cnt_q == '0) begin
          // Capture happens on the edge entering CAPTURE so the sample and
          // the updated sum are visible together with the valid pulse.
          type_d   = in_segment_type;
          weight_d = in_segment_weight;
          sum_d    = w_sum_ext[16] ? 16'hFFFF : w_sum_ext[15:0];
          state_d  = S_CAPTURE;
        end else begin
          cnt_d = cnt_q - C_CNT_ONE;
        end
      end
      S_CAPTURE: begin
        if (idx_q == C_LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + C_IDX_ONE;
          lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
          state_d = S_CLEAR;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything: the interrupted iteration leaves no trace,
    // so all data registers keep their pre-abort values.
    if (state_q != S_IDLE && in_abort) begin
      state_d  = S_IDLE;
      cnt_d    = cnt_q;
      lfsr_d   = lfsr_q;
      idx_d    = idx_q;
      sum_d    = sum_q;
      type_d   = type_q;
      weight_d = weight_q;
    end
  end

  assign w_in_iter = (state_d == S_CLEAR) || (state_d == S_REDUCE) ||
                     (state_d == S_SELECT) || (state_d == S_CAPTURE);

  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      lfsr_q    <= 8'h01;
      idx_q     <= '0;
      sum_q     <= '0;
      type_q    <= '0;
      weight_q  <= '0;
      rst_red_q <= 1'b0;
      en_red_q  <= 1'b0;
      rst_sel_q <= 1'b0;
      en_sel_q  <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      seed_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      idx_q     <= idx_d;
      sum_q     <= sum_d;
      type_q    <= type_d;
      weight_q  <= weight_d;
      rst_red_q <= (state_d == S_CLEAR);
      en_red_q  <= (state_d == S_REDUCE) || (state_d == S_SELECT) || (state_d == S_CAPTURE);
      rst_sel_q <= (state_d == S_CLEAR);
      en_sel_q  <= (state_d == S_SELECT);
      valid_q   <= (state_d == S_CAPTURE);
      done_q    <= (state_d == S_DONE);
      busy_q    <= (state_d != S_IDLE);
      // Seed is only presented while an iteration is in flight.
      seed_q    <= w_in_iter ? lfsr_d : 8'h00;
    end
  end

  assign out_reset_reduce   = rst_red_q;
  assign out_enable_reduce  = en_red_q;
  assign out_reset_select   = rst_sel_q;
  assign out_enable_select  = en_sel_q;
  assign out_seed_select    = seed_q;
  assign out_variable_index = idx_q;
  assign out_sample_valid   = valid_q;
  assign out_sample_type    = type_q;
  assign out_sample_weight  = weight_q;
  assign out_weight_sum     = sum_q;
  assign out_busy           = busy_q;
  assign out_done           = done_q;

endmodule
`default_nettype wire
